// File: rtl/timer_irq_ctrl.sv
// Timer/peripheral interrupt controller: pending, mask, edge/level mode,
// fixed-priority arbitration and an ACK/EOI handshake toward the CPU.
module timer_irq_ctrl #(
  parameter int NUM_SRC = 6,
  parameter int ID_W    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         Addr,
  input  logic               Write_Enabled,
  input  logic [31:0]        Data_In,
  output logic [31:0]        Data_Out,
  input  logic [NUM_SRC-1:0] src_irq,
  input  logic               INT_ACK,
  output logic               INT_REQ,
  output logic [ID_W-1:0]    int_id
);

  localparam int N = NUM_SRC;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t          state;
  logic [N-1:0]    mask;
  logic [N-1:0]    edge_mode;
  logic [N-1:0]    pend;
  logic [N-1:0]    src_prev;
  logic [N-1:0]    active;
  logic [N-1:0]    rise;
  logic [N-1:0]    w1c;
  logic [N-1:0]    ack_clr;
  logic [N-1:0]    pend_nx;
  logic [ID_W-1:0] sel_id;
  logic [ID_W-1:0] isr_id;
  logic [ID_W-1:0] winner;
  logic            wr_mask;
  logic            wr_pend;
  logic            wr_edge;
  logic            eoi;
  logic            take_ack;
  logic            any_active;
  logic            unused_din;

  assign unused_din = ^Data_In[31:N];

  assign wr_mask    = Write_Enabled && (Addr == 2'b00);
  assign wr_pend    = Write_Enabled && (Addr == 2'b01);
  assign wr_edge    = Write_Enabled && (Addr == 2'b10);
  assign eoi        = Write_Enabled && (Addr == 2'b11);

  assign active     = pend & mask;
  assign any_active = |active;
  assign rise       = src_irq & ~src_prev;
  assign w1c        = wr_pend ? Data_In[N-1:0] : '0;
  assign take_ack   = (state == REQ) && INT_ACK && any_active;

  // Scan downward so the lowest set index wins.
  always_comb begin
    winner = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (active[i]) winner = ID_W'(i);
    end
  end

  always_comb begin
    ack_clr = '0;
    for (int i = 0; i < N; i++) begin
      ack_clr[i] = take_ack && (sel_id == ID_W'(i));
    end
  end

  // Level bits mirror the line; edge bits latch, and a new edge beats any clear.
  assign pend_nx = (~edge_mode & src_irq)
                 | (edge_mode & (rise | (pend & ~w1c & ~ack_clr)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mask      <= '0;
      edge_mode <= '0;
      pend      <= '0;
      src_prev  <= '0;
      state     <= IDLE;
      sel_id    <= '0;
      isr_id    <= '0;
    end else begin
      src_prev <= src_irq;
      pend     <= pend_nx;
      if (wr_mask) mask <= Data_In[N-1:0];
      if (wr_edge) edge_mode <= Data_In[N-1:0];
      case (state)
        IDLE: begin
          if (any_active) begin
            state  <= REQ;
            sel_id <= winner;
          end
        end
        REQ: begin
          if (!any_active) begin
            state <= IDLE;
          end else begin
            sel_id <= winner;
            if (INT_ACK) begin
              state  <= SERVICE;
              isr_id <= sel_id;
            end
          end
        end
        SERVICE: begin
          if (eoi) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign INT_REQ = (state == REQ);
  assign int_id  = (state == SERVICE) ? isr_id : sel_id;

  always_comb begin
    Data_Out = '0;
    case (Addr)
      2'b00: Data_Out = 32'(mask);
      2'b01: Data_Out = 32'(pend);
      2'b10: Data_Out = 32'(edge_mode);
      default: begin
        Data_Out[31]       = (state == SERVICE);
        Data_Out[ID_W-1:0] = isr_id;
      end
    endcase
  end

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Bench for timer_irq_ctrl: directed handshake scenarios followed by
// random traffic compared against a cycle-level behavioural model.
module tb_timer_irq_ctrl;

  localparam int N   = 6;
  localparam int IDW = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [1:0]     Addr = 2'b00;
  logic           we = 1'b0;
  logic [31:0]    din = '0;
  logic [31:0]    dout;
  logic [N-1:0]   src = '0;
  logic           ack = 1'b0;
  logic           int_req;
  logic [IDW-1:0] int_id;

  int checks = 0;
  int failures = 0;

  bit [N-1:0] m_mask, m_edge, m_pend, m_prev;
  int m_st, m_sel, m_isr;

  timer_irq_ctrl #(.NUM_SRC(N), .ID_W(IDW)) dut (
    .clk(clk),
    .rst(rst),
    .Addr(Addr),
    .Write_Enabled(we),
    .Data_In(din),
    .Data_Out(dout),
    .src_irq(src),
    .INT_ACK(ack),
    .INT_REQ(int_req),
    .int_id(int_id)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_read(logic [1:0] a);
    case (a)
      2'b00: return 32'(m_mask);
      2'b01: return 32'(m_pend);
      2'b10: return 32'(m_edge);
      default: return ((m_st == 2) ? 32'h8000_0000 : 32'h0) | 32'(m_isr);
    endcase
  endfunction

  task automatic m_reset();
    m_mask = '0; m_edge = '0; m_pend = '0; m_prev = '0;
    m_st = 0; m_sel = 0; m_isr = 0;
  endtask

  // One clock: model next state from current inputs, then compare outputs.
  task automatic cycle();
    bit [N-1:0] act, np, nmask, nedge;
    int win, ns, nsel, nisr;
    bit rose, cleared;
    act = m_pend & m_mask;
    win = -1;
    for (int i = N - 1; i >= 0; i--) if (act[i]) win = i;
    for (int i = 0; i < N; i++) begin
      if (!m_edge[i]) begin
        np[i] = src[i];
      end else begin
        rose = src[i] && !m_prev[i];
        cleared = (we && Addr == 2'b01 && din[i])
               || (m_st == 1 && ack && win >= 0 && m_sel == i);
        np[i] = rose || (m_pend[i] && !cleared);
      end
    end
    ns = m_st; nsel = m_sel; nisr = m_isr;
    if (m_st == 0) begin
      if (win >= 0) begin ns = 1; nsel = win; end
    end else if (m_st == 1) begin
      if (win < 0) ns = 0;
      else begin
        nsel = win;
        if (ack) begin ns = 2; nisr = m_sel; end
      end
    end else if (we && Addr == 2'b11) begin
      ns = 0;
    end
    nmask = (we && Addr == 2'b00) ? din[N-1:0] : m_mask;
    nedge = (we && Addr == 2'b10) ? din[N-1:0] : m_edge;
    @(posedge clk);
    #1;
    m_pend = np; m_mask = nmask; m_edge = nedge; m_prev = src;
    m_st = ns; m_sel = nsel; m_isr = nisr;
    check("int_req", 32'(int_req), 32'(m_st == 1));
    check("int_id", 32'(int_id), 32'((m_st == 2) ? m_isr : m_sel));
  endtask

  task automatic rd(logic [1:0] a, string tag);
    Addr = a;
    #1;
    check(tag, dout, m_read(a));
  endtask

  task automatic rdx(logic [1:0] a, string tag, logic [31:0] exp);
    Addr = a;
    #1;
    check(tag, dout, exp);
  endtask

  task automatic bus_wr(logic [1:0] a, logic [31:0] d);
    Addr = a; din = d; we = 1'b1;
    cycle();
    we = 1'b0; din = '0;
  endtask

  initial begin
    int r;
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    rdx(2'b00, "rst_mask", 32'h0);
    rdx(2'b01, "rst_pend", 32'h0);
    rdx(2'b10, "rst_edge", 32'h0);
    rdx(2'b11, "rst_cause", 32'h0);
    check("rst_req", 32'(int_req), 32'h0);
    check("rst_id", 32'(int_id), 32'h0);

    // Masked level pulse: pending follows, no request
    src = 6'h3F;
    cycle();
    rdx(2'b01, "lvl_pend", 32'h3F);
    check("masked_req", 32'(int_req), 32'h0);
    src = '0;
    cycle();
    rdx(2'b01, "lvl_drop", 32'h0);

    // Unimplemented bits read zero
    bus_wr(2'b00, 32'hFFFF_FFFF);
    rdx(2'b00, "mask_wide", 32'h3F);
    bus_wr(2'b10, 32'hFFFF_FFFF);
    rdx(2'b10, "edge_wide", 32'h3F);
    bus_wr(2'b00, 32'h0);

    // Edge path
    bus_wr(2'b10, 32'h01);
    bus_wr(2'b00, 32'h01);
    src = 6'h01;
    cycle();
    src = '0;
    rdx(2'b01, "edge_pend", 32'h1);
    check("edge_req_t1", 32'(int_req), 32'h0);
    cycle();
    check("edge_req_t2", 32'(int_req), 32'h1);
    check("edge_id", 32'(int_id), 32'h0);
    ack = 1'b1;
    cycle();
    ack = 1'b0;
    check("ack_req", 32'(int_req), 32'h0);
    rdx(2'b11, "ack_cause", 32'h8000_0000);
    rdx(2'b01, "ack_pend", 32'h0);
    bus_wr(2'b11, 32'h0);
    rdx(2'b11, "eoi_cause", 32'h0);
    cycle();
    check("eoi_req", 32'(int_req), 32'h0);

    // Priority and pre-emption
    bus_wr(2'b10, 32'h0);
    bus_wr(2'b00, 32'h3F);
    src = 6'h10;
    cycle();
    cycle();
    check("pri_req", 32'(int_req), 32'h1);
    check("pri_id4", 32'(int_id), 32'h4);
    src = 6'h12;
    cycle();
    cycle();
    check("preempt_id1", 32'(int_id), 32'h1);
    ack = 1'b1;
    cycle();
    ack = 1'b0;
    rdx(2'b11, "pri_cause", 32'h8000_0001);
    src = '0;
    bus_wr(2'b11, 32'h0);
    cycle();
    cycle();
    check("pri_idle", 32'(int_req), 32'h0);

    // Withdraw before ACK
    src = 6'h04;
    cycle();
    cycle();
    check("wd_req", 32'(int_req), 32'h1);
    check("wd_id", 32'(int_id), 32'h2);
    bus_wr(2'b00, 32'h0);
    cycle();
    check("wd_drop", 32'(int_req), 32'h0);
    bus_wr(2'b00, 32'h3F);
    check("wd_wait", 32'(int_req), 32'h0);
    cycle();
    check("wd_again", 32'(int_req), 32'h1);
    src = '0;
    cycle();
    cycle();
    check("wd_idle", 32'(int_req), 32'h0);

    // Edge and W1C in the same cycle; re-arm during service
    bus_wr(2'b10, 32'h08);
    bus_wr(2'b00, 32'h08);
    Addr = 2'b01; din = 32'h08; we = 1'b1; src = 6'h08;
    cycle();
    we = 1'b0; din = '0;
    rdx(2'b01, "set_beats_clr", 32'h8);
    cycle();
    check("sim_req", 32'(int_req), 32'h1);
    check("sim_id", 32'(int_id), 32'h3);
    ack = 1'b1;
    cycle();
    ack = 1'b0;
    rdx(2'b01, "sim_ackclr", 32'h0);
    src = '0;
    cycle();
    src = 6'h08;
    cycle();
    src = '0;
    rdx(2'b01, "svc_accum", 32'h8);
    check("svc_noreq", 32'(int_req), 32'h0);
    bus_wr(2'b11, 32'h0);
    check("eoi_gap", 32'(int_req), 32'h0);
    cycle();
    check("rereq", 32'(int_req), 32'h1);
    check("rereq_id", 32'(int_id), 32'h3);

    // Asynchronous reset in service
    ack = 1'b1;
    cycle();
    ack = 1'b0;
    rdx(2'b11, "pre_rst_cause", 32'h8000_0003);
    rst = 1'b0;
    #1;
    check("arst_req", 32'(int_req), 32'h0);
    check("arst_id", 32'(int_id), 32'h0);
    rdx(2'b11, "arst_cause", 32'h0);
    rdx(2'b00, "arst_mask", 32'h0);
    rdx(2'b01, "arst_pend", 32'h0);
    m_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Random traffic against the model
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 3) == 0)
        src = src ^ N'(1 << $urandom_range(0, N - 1));
      if (m_st == 1) ack = ($urandom_range(0, 3) == 0);
      else ack = ($urandom_range(0, 15) == 0);
      r = $urandom_range(0, 19);
      if (r < 4) begin
        we = 1'b1;
        Addr = 2'(r);
        din = $urandom;
        if (r == 0 && $urandom_range(0, 1) == 1) din[N-1:0] = '1;
      end else begin
        we = 1'b0;
        Addr = 2'($urandom_range(0, 3));
      end
      cycle();
      we = 1'b0;
      ack = 1'b0;
      rd(2'($urandom_range(0, 3)), "rnd_rd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
